// File: rtl/mem_bank_arb.sv
// mem_bank_arb: banked memory front-end joining the fetch port and the
// load/store port onto NUM_BANKS word-interleaved single-port SRAMs.
// Both ports are served in the same cycle when they hit different banks;
// a same-bank conflict goes to the data port by default.
// Optional feature macro: MEM_ARB_AGING_EN -- a saturating fetch stall counter
// that hands a conflicted bank to fetch after MAX_STALL consecutive losses.
// Reset (rst) is asynchronous and active-low; every ready is gated by it, so
// no SRAM access can start while it is asserted.
module mem_bank_arb #(
  parameter  int NUM_BANKS = 4,
  parameter  int ADDR_W    = 16,
  parameter  int DATA_W    = 32,
  parameter  int MAX_STALL = 3,
  localparam int BANK_W    = $clog2(NUM_BANKS),
  localparam int ROW_W     = ADDR_W - 2 - BANK_W,
  localparam int STRB_W    = DATA_W / 8
) (
  input  logic                          clk,
  input  logic                          rst,
  // fetch port
  input  logic                          i_req_valid,
  output logic                          i_req_ready,
  input  logic [ADDR_W-1:0]             i_req_addr,
  output logic                          i_rsp_valid,
  output logic [DATA_W-1:0]             i_rsp_data,
  // load/store port
  input  logic                          d_req_valid,
  output logic                          d_req_ready,
  input  logic                          d_req_we,
  input  logic [ADDR_W-1:0]             d_req_addr,
  input  logic [DATA_W-1:0]             d_req_wdata,
  input  logic [STRB_W-1:0]             d_req_wstrb,
  output logic                          d_rsp_valid,
  output logic [DATA_W-1:0]             d_rsp_data,
  // SRAM banks, flattened bank-major
  output logic [NUM_BANKS-1:0]          sram_ceb,
  output logic [NUM_BANKS-1:0]          sram_web,
  output logic [NUM_BANKS*DATA_W-1:0]   sram_bweb,
  output logic [NUM_BANKS*ROW_W-1:0]    sram_a,
  output logic [NUM_BANKS*DATA_W-1:0]   sram_di,
  input  logic [NUM_BANKS*DATA_W-1:0]   sram_do
);

  // Elaboration-time sanity checks on the configuration.
  if (NUM_BANKS < 2 || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_bad_banks
    $error("mem_bank_arb: NUM_BANKS must be a power of 2 and at least 2");
  end
  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("mem_bank_arb: DATA_W must be a whole number of bytes");
  end
  if (MAX_STALL < 1) begin : g_bad_stall
    $error("mem_bank_arb: MAX_STALL must be at least 1");
  end

  // ---------------------------------------------------------------------
  // Address decode: low word bits select the bank, the rest is the row.
  // ---------------------------------------------------------------------
  logic [BANK_W-1:0] i_bank;
  logic [BANK_W-1:0] d_bank;
  logic [ROW_W-1:0]  i_row;
  logic [ROW_W-1:0]  d_row;

  assign i_bank = i_req_addr[2 +: BANK_W];
  assign d_bank = d_req_addr[2 +: BANK_W];
  assign i_row  = i_req_addr[ADDR_W-1 -: ROW_W];
  assign d_row  = d_req_addr[ADDR_W-1 -: ROW_W];

  // Byte-offset bits are deliberately ignored: all accesses are word-aligned.
  logic unused_byte_offset;
  assign unused_byte_offset = ^{i_req_addr[1:0], d_req_addr[1:0]};

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  logic conflict;
  logic i_wins;      // fetch takes the bank on a conflict this cycle
  logic i_grant;
  logic d_grant;
  logic d_wr_grant;
  logic d_rd_grant;

  assign conflict = i_req_valid && d_req_valid && (i_bank == d_bank);

`ifdef MEM_ARB_AGING_EN
  localparam int STALL_W = $clog2(MAX_STALL + 1);

  logic [STALL_W-1:0] i_stall_cnt_reg;
  logic [STALL_W-1:0] i_stall_cnt_next;
  logic               i_stall_sat;

  assign i_stall_sat = (i_stall_cnt_reg == STALL_W'(MAX_STALL));
  assign i_wins      = i_stall_sat;

  // Count consecutive lost fetch cycles; saturate, and clear once the fetch
  // goes through or is withdrawn.
  always_comb begin
    i_stall_cnt_next = i_stall_cnt_reg;
    if (!i_req_valid || i_req_ready) begin
      i_stall_cnt_next = '0;
    end else if (!i_stall_sat) begin
      i_stall_cnt_next = i_stall_cnt_reg + STALL_W'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_stall_cnt_reg <= '0;
    end else begin
      i_stall_cnt_reg <= i_stall_cnt_next;
    end
  end
`else
  // Fixed priority: the data port always takes a conflicted bank.
  assign i_wins = 1'b0;
`endif

  // A port is only held off when it loses a same-bank conflict; an idle port
  // still sees ready. Both readies drop during reset.
  assign i_req_ready = rst && !(conflict && !i_wins);
  assign d_req_ready = rst && !(conflict &&  i_wins);

  assign i_grant    = i_req_valid && i_req_ready;
  assign d_grant    = d_req_valid && d_req_ready;
  assign d_wr_grant = d_grant &&  d_req_we;
  assign d_rd_grant = d_grant && !d_req_we;

  // ---------------------------------------------------------------------
  // Write byte enables -> active-low bit enables.
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] wr_bweb;

  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_bweb
    assign wr_bweb[gi*8 +: 8] = {8{~d_req_wstrb[gi]}};
  end

  // ---------------------------------------------------------------------
  // Per-bank drive. At most one port is granted a given bank, so the two
  // selects are mutually exclusive.
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] bank_do [NUM_BANKS];

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic i_sel;
    logic d_sel;
    logic d_wr_sel;

    assign i_sel    = i_grant && (i_bank == BANK_W'(gi));
    assign d_sel    = d_grant && (d_bank == BANK_W'(gi));
    assign d_wr_sel = d_sel && d_req_we;

    assign sram_ceb[gi]                   = ~(i_sel || d_sel);
    assign sram_web[gi]                   = ~d_wr_sel;
    assign sram_bweb[gi*DATA_W +: DATA_W] = d_wr_sel ? wr_bweb : '1;
    assign sram_di[gi*DATA_W +: DATA_W]   = d_wr_sel ? d_req_wdata : '0;
    assign sram_a[gi*ROW_W +: ROW_W]      = d_sel ? d_row :
                                            (i_sel ? i_row : '0);

    assign bank_do[gi] = sram_do[gi*DATA_W +: DATA_W];
  end

  // ---------------------------------------------------------------------
  // Response bookkeeping: remember which bank each granted read went to, so
  // the matching SRAM output can be steered back one cycle later.
  // ---------------------------------------------------------------------
  logic              i_rsp_vld_reg;
  logic              d_rsp_vld_reg;
  logic [BANK_W-1:0] i_rsp_bank_reg;
  logic [BANK_W-1:0] d_rsp_bank_reg;

  // Record grants; reset drops any response still in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_rsp_vld_reg  <= 1'b0;
      d_rsp_vld_reg  <= 1'b0;
      i_rsp_bank_reg <= '0;
      d_rsp_bank_reg <= '0;
    end else begin
      i_rsp_vld_reg <= i_grant;
      d_rsp_vld_reg <= d_rd_grant;
      if (i_grant) begin
        i_rsp_bank_reg <= i_bank;
      end
      if (d_rd_grant) begin
        d_rsp_bank_reg <= d_bank;
      end
    end
  end

  assign i_rsp_valid = i_rsp_vld_reg;
  assign d_rsp_valid = d_rsp_vld_reg;

  // Data is forced to zero whenever no response is presented.
  assign i_rsp_data = i_rsp_vld_reg ? bank_do[i_rsp_bank_reg] : '0;
  assign d_rsp_data = d_rsp_vld_reg ? bank_do[d_rsp_bank_reg] : '0;

endmodule

// File: doc/mem_bank_arb.md
# mem_bank_arb

Banked memory front-end between the CPU fetch and load/store ports and `NUM_BANKS` word-interleaved `SRAM_wrapper` instances. It generalises the fixed one-IM/one-DM arrangement into one unified, banked address space. Both ports can be served in the same cycle when they target different banks. Same-bank conflicts are arbitrated, with optional aging so fetch is never starved.

## Interface
Parameters:
- `NUM_BANKS`, 4: number of SRAM banks; a power of 2 and at least 2. `BANK_W = $clog2(NUM_BANKS)`.
- `ADDR_W`, 16: byte-address width. `ROW_W = ADDR_W-2-BANK_W`.
- `DATA_W`, 32: word width. `STRB_W = DATA_W/8`.
- `MAX_STALL`, 3: consecutive fetch losses before fetch wins. Used only with `MEM_ARB_AGING_EN`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `i_req_valid` in 1: fetch read request.
- `i_req_ready` out 1: fetch request accepted this cycle.
- `i_req_addr` in ADDR_W: fetch byte address.
- `i_rsp_valid` out 1: fetch data valid.
- `i_rsp_data` out DATA_W: fetch data.
- `d_req_valid` in 1: load/store request.
- `d_req_ready` out 1: load/store request accepted this cycle.
- `d_req_we` in 1: 1 = write, 0 = read.
- `d_req_addr` in ADDR_W: data byte address.
- `d_req_wdata` in DATA_W: write data.
- `d_req_wstrb` in STRB_W: active-high byte enables.
- `d_rsp_valid` out 1: load data valid (reads only).
- `d_rsp_data` out DATA_W: load data.
- `sram_ceb` out NUM_BANKS: per-bank chip enable, active-low.
- `sram_web` out NUM_BANKS: per-bank write enable, active-low.
- `sram_bweb` out NUM_BANKS*DATA_W: per-bank bit write enable, active-low.
- `sram_a` out NUM_BANKS*ROW_W: per-bank row address.
- `sram_di` out NUM_BANKS*DATA_W: per-bank write data.
- `sram_do` in NUM_BANKS*DATA_W: per-bank read data, valid one cycle after access.

## Operation
Address decode:
- Bank = `addr[2+:BANK_W]`. Row = `addr[ADDR_W-1:2+BANK_W]`.
- `addr[1:0]` is ignored; accesses are always word-aligned.

Port acceptance:
- A port is granted when its valid is high and it wins its bank. Handshake is `valid && ready`.
- `ready` is combinational and is 1 unless the port loses a same-bank conflict this cycle. A port with valid low still sees ready=1.
- No conflict (different banks, or only one valid): both requests are granted in the same cycle.
- Same-bank conflict: the data port wins by default, and the loser's ready=0. The requester holds valid and address stable until accepted.

Bank drive:
- A granted bank gets `ceb=0` and the granted port's row address.
- Write: `web=0`, and `bweb` is each wstrb bit inverted and replicated ×8.
- Read: `web=1` and `bweb` all ones.
- Idle banks: `ceb=1`, `web=1`, `bweb` all ones, `a`=0, `di`=0.

Responses:
- Registered grant bookkeeping per port: a valid bit plus the bank index. Reads only.
- The next cycle, `*_rsp_valid`=1 and `*_rsp_data` = `sram_do` slice of the recorded bank.
- `*_rsp_data` is 0 whenever the matching rsp_valid is 0.
- Responses have no backpressure; the CPU must consume them.
- Writes produce no response and complete at grant.

Aging (with macro):
- `i_stall_cnt`, BANK-independent and saturating, increments on each cycle with `i_req_valid && !i_req_ready`.
- It clears on an accepted fetch, or when `i_req_valid` is 0.
- When `i_stall_cnt == MAX_STALL` and a conflict occurs, fetch wins and `d_req_ready`=0.

## Timing
- Grant to response is 1 cycle: a request accepted in cycle N gives rsp_valid in cycle N+1.
- A back-to-back accepted request per port gives 1 response per cycle.
- Reset values, applied asynchronously while `rst`=0:
  - `i_rsp_valid`=0, `d_rsp_valid`=0, rsp_data=0, stall counter=0, registered bank indexes=0.
  - Combinational SRAM outputs are all idle, because every ready is gated by `rst`.
- Reset asserted mid-operation: pending responses are dropped and no SRAM access occurs while `rst`=0.
- First access is possible in the first cycle after `rst` rises.
- Simultaneous same-bank read and write: only one is granted; there is no bypass or forwarding.

## Configuration
- `MEM_ARB_AGING_EN` defined: the aging counter above is compiled in. Fetch waits at most `MAX_STALL` cycles under sustained same-bank data traffic.
- Not defined: there is no counter, data has fixed priority, and `MAX_STALL` is unused.

## Test plan
All scenarios use NUM_BANKS=4 and DATA_W=32.
- Reset: hold `rst`=0 with both valids high. Required: `sram_ceb`=4'hF, both rsp_valid=0, both ready=0.
- Write then fetch: d write to 0x0010, data 0xDEADBEEF, strb 4'hF (bank 0, row 1). Next cycle, fetch read 0x0010. Required: i_rsp_valid one cycle later with 0xDEADBEEF.
- Parallel: i read 0x0004 (bank 1) and d read 0x0008 (bank 2) in the same cycle. Required: both ready=1 and `sram_ceb`=4'b1001. Both rsp_valid next cycle, each carrying its own bank's data.
- Conflict: i read 0x0000 and d read 0x0010 (both bank 0). Required: d granted and i_req_ready=0. Fetch is granted the following cycle.
- Aging: d issues reads to bank 0 for 6 consecutive cycles while i holds 0x0020 (bank 0).
  - With the macro and MAX_STALL=3: i is granted in cycle 4 with d_req_ready=0 in that cycle.
  - Without the macro: i is granted only after d drops valid.
- Byte strobe: d write 0x0000AB00, strb 4'b0010. Required: bank-0 `bweb`=32'hFFFF00FF. A readback shows only byte 1 changed.
